// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: state encoding, default widths and the
// requester-count range check shared by the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_REQ  = 2;
   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_LOCK_MAX = 4;

   localparam int MIN_REQ = 2;
   localparam int MAX_REQ = 4;

   function automatic bit num_req_ok(input int n);
      return (n >= MIN_REQ) && (n <= MAX_REQ);
   endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. The winner is the first
// request found searching upward from rr_ptr+1, wrapping mod NUM_REQ.
module rr_pick
   import dmem_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] win_oh,
   output logic [IDX_W-1:0]   win_idx,
   output logic               valid
);

   always_comb begin
      logic [IDX_W-1:0] j;
      win_oh  = '0;
      win_idx = '0;
      valid   = 1'b0;
      j       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         j = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!valid && req[j]) begin
            valid     = 1'b1;
            win_idx   = j;
            win_oh[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port data memory.
// Define ARB_LOCK_EN to add the lock port (back-to-back owner bursts).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W
`ifdef ARB_LOCK_EN
  ,parameter int LOCK_MAX = DEF_LOCK_MAX
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        we,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
`ifdef ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]        lock,
`endif
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rdata,
   output logic                      mem_enable,
   output logic                      mem_write,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int IDX_W = $clog2(NUM_REQ);

   if (!num_req_ok(NUM_REQ)) begin : g_bad_num_req
      $error("dmem_arbiter: NUM_REQ must be 2..4");
   end

   arb_state_t         state;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   src;
   logic [NUM_REQ-1:0] win_oh;
   logic [IDX_W-1:0]   win_idx;
   logic               win_valid;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .win_oh  (win_oh),
      .win_idx (win_idx),
      .valid   (win_valid)
   );

   // A fresh command comes from the arbitration winner, or from the
   // current owner when a locked burst re-enters ACCESS.
   assign src = (state == IDLE) ? win_idx : owner;

`ifdef ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX) + 1;
   logic [CNT_W-1:0] lock_cnt;
   logic             relock;
   assign relock = lock[owner] && req[owner] &&
                   (int'(lock_cnt) < LOCK_MAX - 1);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= '0;
         rr_ptr     <= IDX_W'(NUM_REQ - 1);
         grant      <= '0;
         ack        <= '0;
         rdata      <= '0;
         mem_enable <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
`ifdef ARB_LOCK_EN
         lock_cnt   <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (win_valid) begin
                  state      <= ACCESS;
                  owner      <= win_idx;
                  rr_ptr     <= win_idx;
                  grant      <= win_oh;
                  mem_enable <= 1'b1;
                  mem_write  <= we[src];
                  mem_addr   <= addr[int'(src)*ADDR_W +: ADDR_W];
                  mem_wdata  <= wdata[int'(src)*DATA_W +: DATA_W];
               end
            end
            ACCESS: begin
               if (!mem_write) rdata <= mem_rdata;
               state      <= DONE;
               ack        <= grant;
               mem_enable <= 1'b0;
               mem_write  <= 1'b0;
               mem_addr   <= '0;
               mem_wdata  <= '0;
            end
            DONE: begin
               ack <= '0;
`ifdef ARB_LOCK_EN
               if (relock) begin
                  state      <= ACCESS;
                  lock_cnt   <= lock_cnt + CNT_W'(1);
                  mem_enable <= 1'b1;
                  mem_write  <= we[src];
                  mem_addr   <= addr[int'(src)*ADDR_W +: ADDR_W];
                  mem_wdata  <= wdata[int'(src)*DATA_W +: DATA_W];
               end else begin
                  state    <= IDLE;
                  grant    <= '0;
                  lock_cnt <= '0;
               end
`else
               state <= IDLE;
               grant <= '0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed cycle tables, reset/lock sequences and a
// randomized run against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

   localparam int N = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [N-1:0] req, we;
   logic [15:0]  addr, wdata;
`ifdef ARB_LOCK_EN
   logic [N-1:0] lock;
`endif
   logic [N-1:0] grant, ack;
   logic [7:0]   rdata, mem_addr, mem_wdata, mem_rdata;
   logic         mem_enable, mem_write;

   logic [7:0] mem [256];
   assign mem_rdata = mem[mem_addr];

   dmem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
`ifdef ARB_LOCK_EN
      .lock       (lock),
`endif
      .grant      (grant),
      .ack        (ack),
      .rdata      (rdata),
      .mem_enable (mem_enable),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // transaction-level reference: phase 0 idle, 1 access, 2 done
   int         m_phase, m_owner, m_last;
   bit         m_we;
   logic [7:0] m_addr, m_wd, m_rdata;
   logic [7:0] ref_mem [256];

   task automatic model_step();
      if (rst) begin
         if (m_phase == 1 && m_we) ref_mem[m_addr] = m_wd;
         m_phase = 0;
         m_last  = N - 1;
         m_rdata = '0;
      end else if (m_phase == 0) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (m_phase == 0 && req[j]) begin
               m_phase = 1;
               m_owner = j;
               m_last  = j;
               m_we    = we[j];
               m_addr  = addr[j*8 +: 8];
               m_wd    = wdata[j*8 +: 8];
            end
         end
      end else if (m_phase == 1) begin
         if (m_we) ref_mem[m_addr] = m_wd;
         else m_rdata = ref_mem[m_addr];
         m_phase = 2;
      end else begin
         m_phase = 0;
      end
   endtask

   task automatic tick(input bit use_model);
      @(posedge clk);
      if (mem_enable && mem_write) mem[mem_addr] = mem_wdata;
      if (use_model) model_step();
      @(negedge clk);
   endtask

   typedef struct {
      bit         rst;
      logic [1:0] req, we;
      logic [7:0] a0, a1, d1;
      logic [1:0] g, k;
      bit         en, wr;
      logic [7:0] ma, md;
      bit         crd;
      logic [7:0] rd;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t v(
      bit r, logic [1:0] rq, logic [1:0] w,
      logic [7:0] a0, logic [7:0] a1, logic [7:0] d1,
      logic [1:0] g, logic [1:0] k, bit en, bit wr,
      logic [7:0] ma, logic [7:0] md, bit crd, logic [7:0] rd);
      return '{r, rq, w, a0, a1, d1, g, k, en, wr, ma, md, crd, rd};
   endfunction

`ifdef ARB_LOCK_EN
   logic [1:0] lk_g [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                             2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
   logic [1:0] lk_k [10] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00,
                             2'b01, 2'b00, 2'b01, 2'b00, 2'b00};
   logic       lk_e [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                             1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

   bit         pend [N];
   bit         drop [N];
   bit         rw   [N];
   logic [7:0] ra   [N];
   logic [7:0] rdv  [N];
   int         dut_acks [N];
   logic [N-1:0] eg, ek;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'h5A;
      mem[8'h30] = 8'h77;
      rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
`ifdef ARB_LOCK_EN
      lock = '0;
`endif

      // rst  req    we     a0     a1     d1   | g  ack en wr ma md crd rd
      tv.push_back(v(1, 2'b11, 2'b00, 8'h10, 8'h30, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 1, 8'h00));
      tv.push_back(v(1, 2'b11, 2'b00, 8'h10, 8'h30, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 1, 8'h00));
      tv.push_back(v(0, 2'b11, 2'b00, 8'h10, 8'h30, 8'h00, 2'b01, 2'b00, 1, 0, 8'h10, 8'h00, 0, 8'h00));
      tv.push_back(v(0, 2'b11, 2'b00, 8'h10, 8'h30, 8'h00, 2'b01, 2'b01, 0, 0, 8'h00, 8'h00, 1, 8'h5A));
      tv.push_back(v(0, 2'b10, 2'b00, 8'h10, 8'h30, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      tv.push_back(v(0, 2'b10, 2'b00, 8'h10, 8'h30, 8'h00, 2'b10, 2'b00, 1, 0, 8'h30, 8'h00, 0, 8'h00));
      tv.push_back(v(0, 2'b10, 2'b00, 8'h10, 8'h30, 8'h00, 2'b10, 2'b10, 0, 0, 8'h00, 8'h00, 1, 8'h77));
      tv.push_back(v(0, 2'b00, 2'b00, 8'h10, 8'h30, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      tv.push_back(v(0, 2'b11, 2'b00, 8'h10, 8'h30, 8'h00, 2'b01, 2'b00, 1, 0, 8'h10, 8'h00, 0, 8'h00));
      tv.push_back(v(0, 2'b11, 2'b00, 8'h10, 8'h30, 8'h00, 2'b01, 2'b01, 0, 0, 8'h00, 8'h00, 1, 8'h5A));
      tv.push_back(v(0, 2'b11, 2'b00, 8'h10, 8'h30, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      tv.push_back(v(0, 2'b11, 2'b00, 8'h10, 8'h30, 8'h00, 2'b10, 2'b00, 1, 0, 8'h30, 8'h00, 0, 8'h00));
      tv.push_back(v(0, 2'b11, 2'b00, 8'h10, 8'h30, 8'h00, 2'b10, 2'b10, 0, 0, 8'h00, 8'h00, 1, 8'h77));
      tv.push_back(v(0, 2'b11, 2'b00, 8'h10, 8'h30, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      tv.push_back(v(0, 2'b11, 2'b00, 8'h10, 8'h30, 8'h00, 2'b01, 2'b00, 1, 0, 8'h10, 8'h00, 0, 8'h00));
      tv.push_back(v(0, 2'b11, 2'b00, 8'h10, 8'h30, 8'h00, 2'b01, 2'b01, 0, 0, 8'h00, 8'h00, 1, 8'h5A));
      tv.push_back(v(0, 2'b00, 2'b00, 8'h10, 8'h30, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      tv.push_back(v(0, 2'b10, 2'b10, 8'h10, 8'h20, 8'hC3, 2'b10, 2'b00, 1, 1, 8'h20, 8'hC3, 0, 8'h00));
      tv.push_back(v(0, 2'b10, 2'b10, 8'h10, 8'h20, 8'hC3, 2'b10, 2'b10, 0, 0, 8'h00, 8'h00, 1, 8'h5A));
      tv.push_back(v(0, 2'b01, 2'b00, 8'h20, 8'h20, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00));
      tv.push_back(v(0, 2'b01, 2'b00, 8'h20, 8'h20, 8'h00, 2'b01, 2'b00, 1, 0, 8'h20, 8'h00, 0, 8'h00));
      tv.push_back(v(0, 2'b01, 2'b00, 8'h20, 8'h20, 8'h00, 2'b01, 2'b01, 0, 0, 8'h00, 8'h00, 1, 8'hC3));
      tv.push_back(v(0, 2'b00, 2'b00, 8'h20, 8'h20, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 0, 8'h00));

      foreach (tv[i]) begin
         rst   = tv[i].rst;
         req   = tv[i].req;
         we    = tv[i].we;
         addr  = {tv[i].a1, tv[i].a0};
         wdata = {tv[i].d1, 8'h00};
         tick(0);
         chk($sformatf("row%0d grant", i), grant, tv[i].g);
         chk($sformatf("row%0d ack", i), ack, tv[i].k);
         chk($sformatf("row%0d mem_enable", i), mem_enable, tv[i].en);
         chk($sformatf("row%0d mem_write", i), mem_write, tv[i].wr);
         if (tv[i].en) chk($sformatf("row%0d mem_addr", i), mem_addr, tv[i].ma);
         if (tv[i].wr) chk($sformatf("row%0d mem_wdata", i), mem_wdata, tv[i].md);
         if (tv[i].crd) chk($sformatf("row%0d rdata", i), rdata, tv[i].rd);
      end

      // reset during ACCESS: no ack, pointer back to NUM_REQ-1
      req = 2'b01; we = 2'b00; addr = {8'h30, 8'h10};
      tick(0);
      chk("midrst access", {grant, 1'b0, mem_enable}, {2'b01, 1'b0, 1'b1});
      rst = 1'b1; req = 2'b11;
      tick(0);
      chk("midrst reset", {grant, ack, mem_enable}, 5'b0);
      rst = 1'b0;
      tick(0);
      chk("midrst regrant", grant, 2'b01);
      chk("midrst no ack", ack, 2'b00);
      tick(0);
      chk("midrst ack", ack, 2'b01);
      chk("midrst rdata", rdata, 8'h5A);
      req = 2'b00;
      tick(0);
      chk("midrst idle", grant, 2'b00);

      // randomized traffic against the model
      for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
      for (int i = 0; i < N; i++) begin
         pend[i] = 0; drop[i] = 0; dut_acks[i] = 0;
      end
      rst = 1'b1; req = '0;
      tick(1);
      for (int c = 0; c < 3000; c++) begin
         if (m_phase == 2) begin
            pend[m_owner] = 0;
            drop[m_owner] = 0;
         end
         if (m_phase == 1 && $urandom_range(0, 3) == 0) begin
            drop[m_owner] = 1;
            ra[m_owner]   = 8'($urandom);
            rdv[m_owner]  = 8'($urandom);
         end
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1;
               rw[i]   = 1'($urandom);
               ra[i]   = 8'($urandom_range(0, 15));
               rdv[i]  = 8'($urandom);
            end
         end
         rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < N; i++) begin
            if (rst) begin
               pend[i] = 0; drop[i] = 0;
            end
            req[i]         = pend[i] && !drop[i];
            we[i]          = rw[i];
            addr[i*8 +: 8]  = ra[i];
            wdata[i*8 +: 8] = rdv[i];
         end
         tick(1);
         eg = '0; ek = '0;
         if (m_phase != 0) eg[m_owner] = 1'b1;
         if (m_phase == 2) ek[m_owner] = 1'b1;
         chk("rnd grant", grant, eg);
         chk("rnd ack", ack, ek);
         chk("rnd mem_enable", mem_enable, m_phase == 1);
         chk("rnd mem_write", mem_write, m_phase == 1 && m_we);
         if (m_phase == 1) chk("rnd mem_addr", mem_addr, m_addr);
         if (m_phase == 1 && m_we) chk("rnd mem_wdata", mem_wdata, m_wd);
         if (m_phase == 2) chk("rnd rdata", rdata, m_rdata);
         for (int i = 0; i < N; i++) if (ack[i]) dut_acks[i]++;
      end
      for (int i = 0; i < N; i++)
         chk($sformatf("rnd served%0d", i), dut_acks[i] != 0, 1);

`ifdef ARB_LOCK_EN
      rst = 1'b1; req = '0; lock = '0;
      tick(0);
      rst = 1'b0; req = 2'b11; we = 2'b00;
      addr = {8'h30, 8'h10}; lock = 2'b01;
      for (int i = 0; i < 10; i++) begin
         tick(0);
         chk($sformatf("lock%0d grant", i), grant, lk_g[i]);
         chk($sformatf("lock%0d ack", i), ack, lk_k[i]);
         chk($sformatf("lock%0d mem_enable", i), mem_enable, lk_e[i]);
      end
      req = '0; lock = '0;
      tick(0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
